// File: rtl/isp_boot_controller_pkg.sv
// Shared definitions for the ISP boot controller: FSM state encoding and
// the default reset-hold length.
package isp_boot_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_START = 3'd4,
    ST_RUN   = 3'd5
  } boot_state_e;

  // Cycles the core is held in reset before the image stream is accepted.
  localparam int DEFAULT_RESET_CYCLES = 4;

endpackage

// File: rtl/isp_boot_controller.sv
// ISP boot controller: holds the core in reset, streams an image into the
// core's ISP port one word per handshake, then releases reset and pulses
// core_start at the requested entry address. Every output is a flop.
module isp_boot_controller
  import isp_boot_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 12,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    boot_req,
  input  logic [ADDRESS_BITS-1:0] boot_base,
  input  logic [ADDRESS_BITS:0]   boot_count,
  input  logic [ADDRESS_BITS-1:0] boot_entry,
  input  logic                    abort,
  input  logic                    word_valid,
  input  logic [DATA_WIDTH-1:0]   word_data,
  output logic                    word_ready,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    isp_write,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [ADDRESS_BITS-1:0] prog_address,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  // One past the last ISP address; a request may end exactly here.
  localparam logic [ADDRESS_BITS+1:0] ADDR_SPAN = {2'b01, {ADDRESS_BITS{1'b0}}};

  // Boot parameters captured with an accepted request.
  typedef struct packed {
    logic [ADDRESS_BITS-1:0] base;
    logic [ADDRESS_BITS:0]   count;
    logic [ADDRESS_BITS-1:0] entry;
  } boot_req_t;

  boot_state_e             state_q, state_d;
  boot_req_t               req_q, req_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [ADDRESS_BITS:0]   word_cnt_q, word_cnt_d;
  logic                    word_ready_q, word_ready_d;
  logic [ADDRESS_BITS-1:0] isp_address_q, isp_address_d;
  logic [DATA_WIDTH-1:0]   isp_data_q, isp_data_d;
  logic                    isp_write_q, isp_write_d;
  logic                    core_reset_q, core_reset_d;
  logic                    core_start_q, core_start_d;
  logic [ADDRESS_BITS-1:0] prog_address_q, prog_address_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [ADDRESS_BITS+1:0] req_end;
  logic                    req_fits;
  logic                    handshake;
  logic                    last_word;

  assign req_end   = {2'b00, boot_base} + {1'b0, boot_count};
  assign req_fits  = (req_end <= ADDR_SPAN);
  // word_ready_q is only ever high while in LOAD.
  assign handshake = word_valid & word_ready_q;
  assign last_word = ((word_cnt_q + (ADDRESS_BITS+1)'(1)) == req_q.count);

  // Next-state and next-output computation for the whole boot sequence.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    hold_cnt_d     = hold_cnt_q;
    word_cnt_d     = word_cnt_q;
    word_ready_d   = word_ready_q;
    isp_address_d  = isp_address_q;
    isp_data_d     = isp_data_q;
    isp_write_d    = 1'b0;
    core_reset_d   = core_reset_q;
    core_start_d   = 1'b0;
    prog_address_d = prog_address_q;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;

    unique case (state_q)
      // RUN behaves like IDLE towards new requests.
      ST_IDLE, ST_RUN: begin
        if (boot_req) begin
          if (req_fits) begin
            state_d      = ST_HOLD;
            req_d.base   = boot_base;
            req_d.count  = boot_count;
            req_d.entry  = boot_entry;
            hold_cnt_d   = '0;
            word_cnt_d   = '0;
            core_reset_d = 1'b1;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            error_d      = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (!abort) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            if (req_q.count == '0) begin
              state_d = ST_DRAIN;
            end else begin
              state_d      = ST_LOAD;
              word_ready_d = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end

      ST_LOAD: begin
        if (!abort && handshake) begin
          isp_write_d   = 1'b1;
          isp_data_d    = word_data;
          isp_address_d = req_q.base + word_cnt_q[ADDRESS_BITS-1:0];
          word_cnt_d    = word_cnt_q + (ADDRESS_BITS+1)'(1);
          if (last_word) begin
            state_d      = ST_DRAIN;
            word_ready_d = 1'b0;
          end
        end
      end

      // Final ISP write is on the port this cycle; release reset after it.
      ST_DRAIN: begin
        if (!abort) begin
          state_d        = ST_START;
          core_reset_d   = 1'b0;
          core_start_d   = 1'b1;
          prog_address_d = req_q.entry;
        end
      end

      ST_START: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort while the core is still in reset: back to IDLE, drop any write.
    if (abort && (state_q == ST_HOLD || state_q == ST_LOAD || state_q == ST_DRAIN)) begin
      state_d      = ST_IDLE;
      core_reset_d = 1'b1;
      word_ready_d = 1'b0;
      busy_d       = 1'b0;
      error_d      = 1'b1;
      isp_write_d  = 1'b0;
      word_cnt_d   = word_cnt_q;
      isp_data_d   = isp_data_q;
      isp_address_d = isp_address_q;
    end
  end

  // State and registered outputs; reset keeps the core in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      hold_cnt_q     <= '0;
      word_cnt_q     <= '0;
      word_ready_q   <= 1'b0;
      isp_address_q  <= '0;
      isp_data_q     <= '0;
      isp_write_q    <= 1'b0;
      core_reset_q   <= 1'b1;
      core_start_q   <= 1'b0;
      prog_address_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      hold_cnt_q     <= hold_cnt_d;
      word_cnt_q     <= word_cnt_d;
      word_ready_q   <= word_ready_d;
      isp_address_q  <= isp_address_d;
      isp_data_q     <= isp_data_d;
      isp_write_q    <= isp_write_d;
      core_reset_q   <= core_reset_d;
      core_start_q   <= core_start_d;
      prog_address_q <= prog_address_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign word_ready   = word_ready_q;
  assign isp_address  = isp_address_q;
  assign isp_data     = isp_data_q;
  assign isp_write    = isp_write_q;
  assign core_reset   = core_reset_q;
  assign core_start   = core_start_q;
  assign prog_address = prog_address_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_isp_boot_controller.sv
// Bench for isp_boot_controller: directed boot scenarios plus random traffic,
// every cycle compared against a sequence-level model of the boot protocol.
module tb_isp_boot_controller;

  localparam int DW = 32;
  localparam int AB = 12;
  localparam int RC = 4;

  logic          clock = 1'b0;
  logic          reset, boot_req, abort, word_valid;
  logic [AB-1:0] boot_base, boot_entry;
  logic [AB:0]   boot_count;
  logic [DW-1:0] word_data;
  logic          word_ready, isp_write, core_reset, core_start, busy, done, error;
  logic [AB-1:0] isp_address, prog_address;
  logic [DW-1:0] isp_data;

  isp_boot_controller #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .RESET_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .boot_req(boot_req), .boot_base(boot_base),
    .boot_count(boot_count), .boot_entry(boot_entry), .abort(abort),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .isp_address(isp_address), .isp_data(isp_data), .isp_write(isp_write),
    .core_reset(core_reset), .core_start(core_start), .prog_address(prog_address),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Sequence-level model: a boot is "in reset" (hold countdown, words left,
  // drain pending), then a one-cycle start, then running.
  bit            m_booting = 0, m_drain = 0, m_starting = 0, m_running = 0;
  bit            m_err = 0, m_wr = 0;
  int            m_hold = 0, m_left = 0, m_taken = 0, m_base = 0, m_entry = 0;
  logic [AB-1:0] m_addr = '0, m_prog = '0;
  logic [DW-1:0] m_data = '0;

  // Observed DUT writes and start pulses, for literal scenario checks.
  logic [AB+DW-1:0] wlog[$];
  int            cyc_n = 0, last_wr_cyc = -1, fall_cyc = -1, start_cnt = 0;
  logic [AB-1:0] start_prog = '0;
  logic          prev_core_reset = 1'b1;

  function automatic bit m_ready();
    return m_booting && m_hold == 0 && !m_drain && m_left > 0;
  endfunction

  task automatic model_step();
    bit rdy;
    rdy  = m_ready();
    m_wr = 0;
    if (reset) begin
      m_booting = 0; m_drain = 0; m_starting = 0; m_running = 0; m_err = 0;
      m_hold = 0; m_left = 0; m_taken = 0;
      m_addr = '0; m_data = '0; m_prog = '0;
    end else if (m_booting) begin
      if (abort) begin
        m_booting = 0; m_drain = 0; m_err = 1;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0 && m_left == 0) m_drain = 1;
      end else if (m_drain) begin
        m_booting = 0; m_drain = 0; m_starting = 1; m_prog = AB'(m_entry);
      end else if (rdy && word_valid) begin
        m_wr = 1; m_data = word_data; m_addr = AB'(m_base + m_taken);
        m_taken++; m_left--;
        if (m_left == 0) m_drain = 1;
      end
    end else if (m_starting) begin
      m_starting = 0; m_running = 1;
    end else if (boot_req) begin
      if (int'(boot_base) + int'(boot_count) <= (1 << AB)) begin
        m_booting = 1; m_running = 0; m_err = 0; m_drain = 0;
        m_hold = RC; m_left = int'(boot_count); m_taken = 0;
        m_base = int'(boot_base); m_entry = int'(boot_entry);
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic compare();
    chk("word_ready",   64'(word_ready),   64'(m_ready()));
    chk("isp_write",    64'(isp_write),    64'(m_wr));
    chk("isp_address",  64'(isp_address),  64'(m_addr));
    chk("isp_data",     64'(isp_data),     64'(m_data));
    chk("core_reset",   64'(core_reset),   64'(!(m_starting || m_running)));
    chk("core_start",   64'(core_start),   64'(m_starting));
    chk("prog_address", 64'(prog_address), 64'(m_prog));
    chk("busy",         64'(busy),         64'(m_booting || m_starting));
    chk("done",         64'(done),         64'(m_running));
    chk("error",        64'(error),        64'(m_err));
    if (isp_write === 1'b1) begin
      wlog.push_back({isp_address, isp_data});
      last_wr_cyc = cyc_n;
    end
    if (prev_core_reset === 1'b1 && core_reset === 1'b0) fall_cyc = cyc_n;
    prev_core_reset = core_reset;
    if (core_start === 1'b1) begin
      start_cnt++;
      start_prog = prog_address;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    cyc_n++;
    compare();
  endtask

  task automatic clear_log();
    wlog.delete();
    last_wr_cyc = -1; fall_cyc = -1; start_cnt = 0; start_prog = '0;
  endtask

  task automatic boot(input int base, input int count, input int entry);
    boot_req = 1'b1; boot_base = AB'(base); boot_count = (AB+1)'(count); boot_entry = AB'(entry);
    cyc();
    boot_req = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (word_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("ready_wait", 64'(word_ready), 64'd1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    word_valid = 1'b1; word_data = d;
    cyc();
    word_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic chk_wr(input string nm, input int idx, input int addr, input int data);
    logic [AB+DW-1:0] e;
    e = {AB'(addr), DW'(data)};
    if (idx < wlog.size()) chk(nm, 64'(wlog[idx]), 64'(e));
    else chk(nm, 64'hdead, 64'(e));
  endtask

  initial begin
    reset = 1'b1; boot_req = 1'b0; abort = 1'b0; word_valid = 1'b0;
    boot_base = '0; boot_count = '0; boot_entry = '0; word_data = '0;

    // Reset state
    do_reset();
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);

    // Normal boot, back-to-back words
    clear_log();
    boot(12'h010, 3, 12'h010);
    wait_ready();
    word_valid = 1'b1;
    word_data = 32'hA; cyc();
    word_data = 32'hB; cyc();
    word_data = 32'hC; cyc();
    word_valid = 1'b0;
    repeat (4) cyc();
    chk("norm_nwr", 64'(wlog.size()), 64'd3);
    chk_wr("norm_wr0", 0, 12'h010, 32'hA);
    chk_wr("norm_wr1", 1, 12'h011, 32'hB);
    chk_wr("norm_wr2", 2, 12'h012, 32'hC);
    chk("norm_rst_fall", 64'(fall_cyc), 64'(last_wr_cyc + 1));
    chk("norm_starts", 64'(start_cnt), 64'd1);
    chk("norm_entry", 64'(start_prog), 64'h010);
    chk("norm_done", 64'(done), 64'd1);

    // Gapped stream
    clear_log();
    boot(12'h100, 2, 12'h100);
    wait_ready();
    send(32'h11);
    cyc();
    cyc();
    send(32'h22);
    repeat (4) cyc();
    chk("gap_nwr", 64'(wlog.size()), 64'd2);
    chk_wr("gap_wr0", 0, 12'h100, 32'h11);
    chk_wr("gap_wr1", 1, 12'h101, 32'h22);

    // Overflowing request is refused; exact fit is accepted
    do_reset();
    clear_log();
    boot(12'hFFE, 3, 0);
    cyc();
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_busy", 64'(busy), 64'd0);
    chk("ovf_core_reset", 64'(core_reset), 64'd1);
    boot(12'hFFE, 2, 12'h001);
    wait_ready();
    send(32'h5);
    send(32'h6);
    repeat (4) cyc();
    chk_wr("fit_wr0", 0, 12'hFFE, 32'h5);
    chk_wr("fit_wr1", 1, 12'hFFF, 32'h6);
    chk("fit_error", 64'(error), 64'd0);

    // Zero-length image
    clear_log();
    boot(0, 0, 12'h020);
    repeat (8) cyc();
    chk("zero_nwr", 64'(wlog.size()), 64'd0);
    chk("zero_entry", 64'(start_prog), 64'h020);
    chk("zero_done", 64'(done), 64'd1);

    // Abort after first word
    clear_log();
    boot(12'h200, 4, 12'h200);
    wait_ready();
    send(32'h1);
    abort = 1'b1; cyc(); abort = 1'b0;
    cyc();
    chk("abt1_nwr", 64'(wlog.size()), 64'd1);
    chk("abt1_error", 64'(error), 64'd1);
    chk("abt1_core_reset", 64'(core_reset), 64'd1);
    chk("abt1_ready", 64'(word_ready), 64'd0);

    // Abort coincident with the final word
    boot(12'h200, 4, 12'h200);
    wait_ready();
    clear_log();
    send(32'h1); send(32'h2); send(32'h3);
    word_valid = 1'b1; word_data = 32'h4; abort = 1'b1;
    cyc();
    word_valid = 1'b0; abort = 1'b0;
    repeat (3) cyc();
    chk("abt4_nwr", 64'(wlog.size()), 64'd3);
    chk_wr("abt4_wr2", 2, 12'h202, 32'h3);
    chk("abt4_error", 64'(error), 64'd1);
    chk("abt4_starts", 64'(start_cnt), 64'd0);

    // Reset mid-load, then a clean re-boot
    boot(12'h300, 4, 12'h300);
    wait_ready();
    send(32'h31); send(32'h32);
    reset = 1'b1; word_valid = 1'b1; word_data = 32'h33;
    cyc();
    reset = 1'b0; word_valid = 1'b0;
    cyc();
    clear_log();
    cyc();
    chk("rrb_idle_wr", 64'(wlog.size()), 64'd0);
    boot(12'h050, 2, 12'h050);
    wait_ready();
    send(32'h51); send(32'h52);
    repeat (4) cyc();
    chk_wr("rrb_wr0", 0, 12'h050, 32'h51);
    chk_wr("rrb_wr1", 1, 12'h051, 32'h52);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom % 300) == 0;
      boot_req   = ($urandom % 8) == 0;
      boot_base  = AB'($urandom);
      boot_count = (($urandom % 8) == 0) ? (AB+1)'($urandom % 4097) : (AB+1)'($urandom % 9);
      boot_entry = AB'($urandom);
      abort      = ($urandom % 30) == 0;
      word_valid = ($urandom % 3) != 0;
      word_data  = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/isp_boot_controller.md
ISP_BOOT_CONTROLLER -- requirements
Module: isp_boot_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of an instruction/data word.
REQ-002 Parameter ADDRESS_BITS, default 12, sets the width of the core word address.
REQ-003 Parameter RESET_CYCLES, default 4, sets the number of cycles the core is held in reset before loading (minimum 1).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 boot_req  input  1  single-cycle request to start a boot sequence.
REQ-007 boot_base  input  ADDRESS_BITS  first ISP word address; sampled with an accepted boot_req.
REQ-008 boot_count  input  ADDRESS_BITS+1  number of words to load; sampled with an accepted boot_req.
REQ-009 boot_entry  input  ADDRESS_BITS  program start address; sampled with an accepted boot_req.
REQ-010 abort  input  1  cancels an in-progress boot.
REQ-011 word_valid / word_data  input  1 / DATA_WIDTH  image word stream from the peripheral.
REQ-012 word_ready  output  1  controller accepts word_data this cycle.
REQ-013 isp_address / isp_data / isp_write  output  ADDRESS_BITS / DATA_WIDTH / 1  drives the core ISP port.
REQ-014 core_reset / core_start / prog_address  output  1 / 1 / ADDRESS_BITS  drive the core reset, start and prog_address inputs.
REQ-015 busy / done / error  output  1 each  status flags.

Function
REQ-016 The FSM SHALL have states IDLE, HOLD, LOAD, DRAIN, START and RUN; all outputs SHALL be registered.
REQ-017 In IDLE, a boot_req SHALL be accepted when boot_base + boot_count <= 2^ADDRESS_BITS; the controller then moves to HOLD, clears done and error, and sets busy.
REQ-018 In IDLE, a boot_req with boot_base + boot_count > 2^ADDRESS_BITS SHALL leave the state unchanged and set error the next cycle.
REQ-019 A boot_req arriving in HOLD, LOAD, DRAIN or START SHALL be ignored; one arriving in RUN SHALL be treated as a request in IDLE.
REQ-020 HOLD: core_reset=1 for exactly RESET_CYCLES cycles, then go to LOAD, or to DRAIN if boot_count==0.
REQ-021 LOAD: word_ready=1 and core_reset=1; each word_valid&word_ready handshake SHALL produce isp_write=1 on the next cycle with isp_data=word_data and isp_address=boot_base+n, where n counts accepted words from 0.
REQ-022 Cycles in LOAD without word_valid SHALL produce isp_write=0 and leave the address counter unchanged; back-to-back words SHALL sustain one write per cycle.
REQ-023 Acceptance of word number boot_count-1 SHALL move the FSM to DRAIN, with word_ready=0 from the following cycle.
REQ-024 DRAIN SHALL last one cycle with core_reset=1, so the final ISP write completes before reset releases.
REQ-025 START SHALL last one cycle with core_reset=0, core_start=1 and prog_address=boot_entry, then go to RUN.
REQ-026 RUN: core_reset=0, core_start=0, busy=0, done=1; prog_address SHALL hold boot_entry.
REQ-027 An abort in HOLD, LOAD or DRAIN SHALL go to IDLE next cycle with core_reset=1, word_ready=0, busy=0 and error=1, and SHALL suppress any pending isp_write.
REQ-028 If abort and a final-word handshake occur in the same cycle, abort SHALL win.
REQ-029 abort in IDLE, START or RUN SHALL have no effect.
REQ-030 isp_write SHALL never be asserted outside the cycle after a LOAD handshake.

Reset
REQ-031 Reset SHALL force: state IDLE, core_reset=1, core_start=0, prog_address=0, isp_write=0, isp_address=0, isp_data=0, word_ready=0, busy=0, done=0, error=0, and all counters 0.
REQ-032 Reset asserted mid-boot SHALL abandon the sequence with no further isp_write; the core SHALL remain in reset.

Structure
REQ-033 The state encoding and the RESET_CYCLES default SHALL live in the shared core package.
REQ-034 No sub-modules; a single FSM with a hold counter and a word/address counter.

Verification
REQ-035 Normal boot: base=0x010, count=3, entry=0x010, words 0xA,0xB,0xC back-to-back -> writes (0x010,0xA),(0x011,0xB),(0x012,0xC) on consecutive cycles; core_reset falls 1 cycle after the last write; a 1-cycle core_start with prog_address=0x010; then done=1.
REQ-036 Gapped stream: word_valid toggles 1,0,0,1 with count=2 -> exactly 2 writes at base and base+1; no write in the gap cycles.
REQ-037 Overflow: base=0xFFE, count=3 -> error=1, no HOLD, core_reset stays 1; base=0xFFE, count=2 -> accepted, writes at 0xFFE and 0xFFF.
REQ-038 Zero count: count=0, entry=0x020 -> HOLD for 4 cycles, DRAIN, START with prog_address=0x020; no isp_write.
REQ-039 Abort after 1 of 4 words, and again coincident with the 4th word -> IDLE, error=1, core_reset=1; no write for the aborted word.
REQ-040 Reset during LOAD, then a new boot_req -> clean re-boot from word 0 at the new base.
